pipe_regwall_chain: RTL

//  Parametrised chain of pipeline register walls (IF/ID .. WB) with per-stage valid bits, hold, flush and bubble insertion.

---
 rtl/pipe_regwall_chain.sv | 137 +++++++++++++
 1 files changed

// File: rtl/pipe_regwall_chain.sv
// Chain of STAGES pipeline register walls with hold, flush, bubble insertion and forwarding lookup.
// Optional perf counters are enabled by defining PIPE_PERF_CNT_EN.
module pipe_regwall_chain #(
  parameter int STAGES = 4,
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_wr_en,
  input  logic [ADDR_W-1:0]        in_wr_addr,
  output logic                     in_ready,
  input  logic [STAGES-1:0]        hold,
  input  logic [STAGES-1:0]        flush,
  output logic [STAGES-1:0]        stage_valid,
  output logic [STAGES*WIDTH-1:0]  stage_data,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  input  logic [ADDR_W-1:0]        fwd_addr,
  output logic [STAGES-1:0]        fwd_hit,
  output logic                     fwd_any,
  output logic [WIDTH-1:0]         fwd_data,
  output logic [31:0]              bubble_cnt,
  output logic [31:0]              flush_cnt
);

  logic [STAGES-1:0]              r_valid;
  logic [STAGES-1:0][WIDTH-1:0]   r_data;
  logic [STAGES-1:0]              r_wr_en;
  logic [STAGES-1:0][ADDR_W-1:0]  r_wr_addr;

  logic [STAGES-1:0]              w_h;
  logic [STAGES-1:0]              w_bubble;
  logic [STAGES-1:0]              w_prev_valid;
  logic [STAGES-1:0][WIDTH-1:0]   w_prev_data;
  logic [STAGES-1:0]              w_prev_wr_en;
  logic [STAGES-1:0][ADDR_W-1:0]  w_prev_wr_addr;
  logic [STAGES-1:0]              w_fwd_hit;
  logic [WIDTH-1:0]               w_fwd_data;

  // A stall at stage k freezes every younger stage as well.
  always_comb begin
    w_h = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_h[k] = |(hold >> k);
    end
  end

  // Source of each stage's load: stage 0 takes the in_* port, stage k takes stage k-1.
  assign w_prev_valid   = {r_valid[STAGES-2:0],   in_valid};
  assign w_prev_data    = {r_data[STAGES-2:0],    in_data};
  assign w_prev_wr_en   = {r_wr_en[STAGES-2:0],   in_wr_en};
  assign w_prev_wr_addr = {r_wr_addr[STAGES-2:0], in_wr_addr};

  // Stage k empties when it is free to move but its feeder is stalled.
  assign w_bubble = ~flush & ~w_h & {w_h[STAGES-2:0], 1'b0};

  // NOTE: sequential state uses non-blocking assignments so every wall samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid   <= '0;
      r_data    <= '0;
      r_wr_en   <= '0;
      r_wr_addr <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (flush[k] || w_bubble[k]) begin
          r_valid[k]   <= 1'b0;
          r_data[k]    <= '0;
          r_wr_en[k]   <= 1'b0;
          r_wr_addr[k] <= '0;
        end else if (!w_h[k]) begin
          r_valid[k]   <= w_prev_valid[k];
          r_data[k]    <= w_prev_valid[k] ? w_prev_data[k]    : '0;
          r_wr_en[k]   <= w_prev_valid[k] ? w_prev_wr_en[k]   : 1'b0;
          r_wr_addr[k] <= w_prev_valid[k] ? w_prev_wr_addr[k] : '0;
        end
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_fwd_hit  = '0;
    w_fwd_data = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      w_fwd_hit[k] = r_valid[k] & r_wr_en[k] & (r_wr_addr[k] == fwd_addr) & (fwd_addr != '0);
      if (w_fwd_hit[k]) w_fwd_data = r_data[k];
    end
  end

  assign in_ready    = ~w_h[0];
  assign stage_valid = r_valid;
  assign stage_data  = r_data;
  assign out_valid   = r_valid[STAGES-1];
  assign out_data    = r_data[STAGES-1];
  assign fwd_hit     = w_fwd_hit;
  assign fwd_any     = |w_fwd_hit;
  assign fwd_data    = w_fwd_data;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_bubble_cnt;
  logic [31:0] r_flush_cnt;

  function automatic logic [3:0] popcount(input logic [STAGES-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < STAGES; i++) n = n + 4'(v[i]);
    return n;
  endfunction

  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [3:0] b);
    logic [32:0] s;
    s = {1'b0, a} + 33'(b);
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_bubble_cnt <= '0;
      r_flush_cnt  <= '0;
    end else begin
      r_bubble_cnt <= sat_add(r_bubble_cnt, popcount(w_bubble));
      r_flush_cnt  <= sat_add(r_flush_cnt, popcount(flush & r_valid));
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign flush_cnt  = r_flush_cnt;
`else
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule
